fir_band_scheduler: RTL and testbench
=====================================

FIR_BAND_SCHEDULER -- requirements
Module: fir_band_scheduler

Interface
REQ-001 SHALL have parameters: NBANDS, default 4, number of band filters sequenced; DW, default 10, sample/coefficient word width (10-bit float format); WDOG_MAX, default 255, watchdog limit in clk_fast cycles.
REQ-002 SHALL have ports (name  direction  width  meaning): clk_fast  in  1  sole clock, all state on rising edge; rst  in  1  asynchronous active-high reset.
REQ-003 sample_in  in  DW  input sample; sample_valid  in  1  sample_in valid this cycle; flush  in  1  request to clear band delay lines.
REQ-004 band_mask  in  NBANDS  1 = band enabled; sampled only at sample acceptance.
REQ-005 band_sample  out  DW  captured sample driven to all band filters; band_en  out  NBANDS  one-cycle start pulse per band; band_clr  out  1  one-cycle delay-line clear to all bands.
REQ-006 band_out  in  NBANDS*DW  band results, band b at bits [b*DW +: DW]; band_avl  in  NBANDS  band result-available level.
REQ-007 out_bands  out  NBANDS*DW  collected results, same packing; out_valid  out  1  one-cycle result strobe; busy  out  1  high in every state except IDLE.
REQ-008 drop_cnt  out  8  saturating count of rejected samples; timeout_err  out  1  sticky watchdog flag.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; current band index b is a counter of width clog2(NBANDS).
REQ-010 IDLE: flush=1 -> band_clr=1 next cycle, stay IDLE, sample_valid in same cycle rejected; else sample_valid=1 -> capture sample_in into band_sample, snapshot band_mask, clear out_bands, b = lowest enabled band, go ISSUE; if snapshot all zero go DONE instead.
REQ-011 ISSUE: band_en[b]=1 for exactly one cycle, all other bits 0, go WAIT.
REQ-012 WAIT: rising edge of band_avl[b] (current 1, registered previous 0) -> capture band_out slice b into out_bands slice b; then b = next higher enabled band and go ISSUE, or go DONE if none remain.
REQ-013 avl edge-detect register SHALL update every cycle in every state; edges on bands other than b are ignored.
REQ-014 DONE: out_valid=1 for one cycle, out_bands stable from DONE until next acceptance; go IDLE.
REQ-015 Masked bands SHALL never receive band_en and their out_bands slice SHALL read zero.
REQ-016 Latency: acceptance at cycle T -> first band_en at T+1; per enabled band, ISSUE to slice capture = band latency + 1; out_valid one cycle after last capture; all-masked -> out_valid at T+1.
REQ-017 sample_valid=1 in any state other than IDLE, or in IDLE with flush=1, SHALL increment drop_cnt, saturating at 255.
REQ-018 flush=1 while busy SHALL set a pending flag; band_clr issued the cycle after return to IDLE, with priority over sample_valid that cycle; multiple requests while busy merge into one pulse.
REQ-019 band_sample SHALL hold its value through the whole sequence regardless of sample_in.

Reset
REQ-020 rst=1 SHALL asynchronously force: state IDLE, b=0, band_sample=0, out_bands=0, band_en=0, band_clr=0, out_valid=0, busy=0, drop_cnt=0, timeout_err=0, pending flush=0, avl edge register=0, watchdog=0.
REQ-021 Reset mid-sequence SHALL abandon the sequence with no out_valid; first acceptance is permitted the cycle after rst deasserts.

Configuration
REQ-022 Macro FIR_BAND_SCHED_WDOG_EN defined: watchdog counter clears on ISSUE, increments each WAIT cycle; on reaching WDOG_MAX without edge, slice b = all ones (DW'h3FF), timeout_err set (cleared only by rst), sequence advances as in REQ-012.
REQ-023 Macro not defined: no watchdog logic, WAIT waits indefinitely, timeout_err tied 0.

Verification
REQ-024 mask=4'b1111, each band model raises avl 5 cycles after band_en, sample 10'h155 -> band_en pulses 4'b0001,0010,0100,1000 in order, one out_valid, out_bands equal model results, busy high throughout.
REQ-025 mask=4'b0101 -> only band_en[0], band_en[2] pulse; out_bands slices 1 and 3 read 10'h000.
REQ-026 mask=4'b0000 with sample_valid at T -> out_valid at T+1, out_bands all zero, no band_en.
REQ-027 3 sample_valid pulses plus 1 flush while busy -> drop_cnt=3, single band_clr the cycle after return to IDLE; 300 rejected samples -> drop_cnt=255.
REQ-028 With FIR_BAND_SCHED_WDOG_EN, band 2 avl never rises -> after 255 WAIT cycles slice 2 = 10'h3FF, timeout_err=1, band 3 still issued, out_valid asserted; without macro, bench sees busy held high.
REQ-029 rst pulsed while in WAIT for band 1 -> all outputs zero immediately, no out_valid, next sample accepted the cycle after rst falls.

Source files
------------

// File: rtl/fir_band_scheduler_if.sv
// fir_band_scheduler_if: sample intake, band-filter control/result bus and
// collected-result bus of the band scheduler, bundled for port connection.
interface fir_band_scheduler_if #(
    parameter int NBANDS = 4,
    parameter int DW     = 10
);
    logic [DW-1:0]        sample_in;
    logic                 sample_valid;
    logic                 flush;
    logic [NBANDS-1:0]    band_mask;
    logic [DW-1:0]        band_sample;
    logic [NBANDS-1:0]    band_en;
    logic                 band_clr;
    logic [NBANDS*DW-1:0] band_out;
    logic [NBANDS-1:0]    band_avl;
    logic [NBANDS*DW-1:0] out_bands;
    logic                 out_valid;
    logic                 busy;
    logic [7:0]           drop_cnt;
    logic                 timeout_err;

    // Scheduler side
    modport slave (
        input  sample_in, sample_valid, flush, band_mask, band_out, band_avl,
        output band_sample, band_en, band_clr, out_bands, out_valid, busy,
               drop_cnt, timeout_err
    );

    // Sample source / band filters / result consumer side
    modport master (
        output sample_in, sample_valid, flush, band_mask, band_out, band_avl,
        input  band_sample, band_en, band_clr, out_bands, out_valid, busy,
               drop_cnt, timeout_err
    );
endinterface

// File: rtl/fir_band_scheduler.sv
// fir_band_scheduler: takes one sample, starts each enabled band filter in
// ascending order (one at a time), collects each band's result on the rising
// edge of its avl line, then strobes out_valid with all slices.
// Optional per-band watchdog: define FIR_BAND_SCHED_WDOG_EN.
module fir_band_scheduler #(
    parameter int NBANDS   = 4,
    parameter int DW       = 10,
    parameter int WDOG_MAX = 255
) (
    input  logic                clk_fast,
    input  logic                rst,
    fir_band_scheduler_if.slave bus
);
    localparam int BW = (NBANDS > 1) ? $clog2(NBANDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [BW-1:0]     r_band;
    logic [NBANDS-1:0] r_mask;
    logic [NBANDS-1:0] r_avl_prev;
    logic [DW-1:0]     r_sample;
    logic [DW-1:0]     r_slice [NBANDS];
    logic              r_band_clr;
    logic              r_flush_pend;
    logic [7:0]        r_drop_cnt;

    logic              w_flush_req;
    logic              w_accept;
    logic              w_reject;
    logic              w_edge;
    logic              w_timeout;
    logic              w_wait_done;
    logic [BW-1:0]     w_first_band;
    logic              w_any;
    logic [BW-1:0]     w_next_band;
    logic              w_more;
    logic [NBANDS-1:0] w_band_en;
    logic              w_out_valid;
    logic              w_busy;

    // A flush seen while busy is replayed in the first IDLE cycle, where it
    // outranks a sample arriving in that same cycle.
    assign w_flush_req = bus.flush | r_flush_pend;
    assign w_accept    = (r_state == S_IDLE) && bus.sample_valid && !w_flush_req;
    assign w_reject    = bus.sample_valid && ((r_state != S_IDLE) || w_flush_req);
    assign w_edge      = bus.band_avl[r_band] && !r_avl_prev[r_band];
    assign w_wait_done = (r_state == S_WAIT) && (w_edge || w_timeout);

    // State register
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_next = w_any ? S_ISSUE : S_DONE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (w_wait_done) w_state_next = w_more ? S_ISSUE : S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from state and current band
    always_comb begin
        w_band_en   = '0;
        w_out_valid = (r_state == S_DONE);
        w_busy      = (r_state != S_IDLE);
        if (r_state == S_ISSUE) w_band_en[r_band] = 1'b1;
    end

    // Lowest enabled band in the incoming mask (first band of a sequence)
    always_comb begin
        w_first_band = '0;
        w_any        = 1'b0;
        for (int i = NBANDS - 1; i >= 0; i--) begin
            if (bus.band_mask[i]) begin
                w_first_band = BW'(i);
                w_any        = 1'b1;
            end
        end
    end

    // Next enabled band above the current one in the captured mask
    always_comb begin
        w_next_band = '0;
        w_more      = 1'b0;
        for (int i = NBANDS - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_band))) begin
                w_next_band = BW'(i);
                w_more      = 1'b1;
            end
        end
    end

    // Sequence bookkeeping: sample/mask capture, band pointer, flush, drops
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            r_band       <= '0;
            r_mask       <= '0;
            r_avl_prev   <= '0;
            r_sample     <= '0;
            r_band_clr   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_avl_prev <= bus.band_avl;
            r_band_clr <= (r_state == S_IDLE) && w_flush_req;
            if (r_state == S_IDLE)  r_flush_pend <= 1'b0;
            else if (bus.flush)     r_flush_pend <= 1'b1;
            if (w_reject && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_accept) begin
                r_sample <= bus.sample_in;
                r_mask   <= bus.band_mask;
                r_band   <= w_first_band;
            end else if (w_wait_done && w_more) begin
                r_band <= w_next_band;
            end
        end
    end

    // Per-band result slice: cleared on acceptance, loaded when its band finishes
    for (genvar gi = 0; gi < NBANDS; gi++) begin : g_slice
        always_ff @(posedge clk_fast or posedge rst) begin
            if (rst)
                r_slice[gi] <= '0;
            else if (w_accept)
                r_slice[gi] <= '0;
            else if (w_wait_done && (r_band == BW'(gi)))
                r_slice[gi] <= w_edge ? bus.band_out[gi*DW +: DW] : '1;
        end
        assign bus.out_bands[gi*DW +: DW] = r_slice[gi];
    end

`ifdef FIR_BAND_SCHED_WDOG_EN
    localparam int WW = (WDOG_MAX > 1) ? $clog2(WDOG_MAX + 1) : 1;
    logic [WW-1:0] r_wdog;
    logic          r_timeout_err;

    // Watchdog: restarted by each issue, counts cycles spent waiting
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst)                     r_wdog <= '0;
        else if (r_state == S_ISSUE) r_wdog <= '0;
        else if (r_state == S_WAIT)  r_wdog <= r_wdog + WW'(1);
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst)            r_timeout_err <= 1'b0;
        else if (w_timeout) r_timeout_err <= 1'b1;
    end

    // Expire in the WAIT cycle in which the count reaches the limit
    assign w_timeout       = (r_state == S_WAIT) && !w_edge && (r_wdog == WW'(WDOG_MAX - 1));
    assign bus.timeout_err = r_timeout_err;
`else
    // Without the watchdog a band may take as long as it likes
    assign w_timeout       = 1'b0;
    assign bus.timeout_err = 1'b0;
    if (WDOG_MAX < 1) begin : g_wdog_limit_unused
    end
`endif

    assign bus.band_sample = r_sample;
    assign bus.band_en     = w_band_en;
    assign bus.band_clr    = r_band_clr;
    assign bus.out_valid   = w_out_valid;
    assign bus.busy        = w_busy;
    assign bus.drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_fir_band_scheduler.sv
// tb_fir_band_scheduler: directed + randomized checks of fir_band_scheduler
// against a transaction-level model (issue order, completion cycle, results).
module tb_fir_band_scheduler;
    localparam int NB   = 4;
    localparam int DW   = 10;
    localparam int WDOG = 255;

    logic clk_fast = 1'b0;
    logic rst      = 1'b0;
    always #5 clk_fast = ~clk_fast;

    fir_band_scheduler_if #(.NBANDS(NB), .DW(DW)) bus ();

    fir_band_scheduler #(.NBANDS(NB), .DW(DW), .WDOG_MAX(WDOG)) dut (
        .clk_fast (clk_fast),
        .rst      (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // band filter models
    int            lat   [NB];
    logic [DW-1:0] val   [NB];
    int            cnt   [NB];
    bit            never [NB];

    // observation log
    logic [31:0]       en_enc;
    int                en_len;
    int                ov_seen, ov_cyc, clr_seen, clr_cyc, busy_low, bs_bad;
    logic [NB*DW-1:0]  ov_bands;
    bit                rec;
    logic [DW-1:0]     exp_sample;
    int                exp_drop;
    logic              exp_tmo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // one clock: observe outputs of the new cycle, then step band models
    task automatic tick();
        @(posedge clk_fast);
        #1;
        cyc++;
        if (bus.band_en != '0) begin
            int idx;
            int ones;
            idx  = -1;
            ones = 0;
            for (int b = 0; b < NB; b++) if (bus.band_en[b]) begin idx = b; ones++; end
            if (ones != 1) idx = 15;
            en_enc = (en_enc << 4) | 32'(idx);
            en_len++;
        end
        if (rec) begin
            if (!bus.busy) busy_low++;
            if (bus.band_sample !== exp_sample) bs_bad++;
        end
        if (bus.out_valid) begin
            ov_seen++;
            ov_cyc   = cyc;
            ov_bands = bus.out_bands;
            rec      = 1'b0;
        end
        if (bus.band_clr) begin
            clr_seen++;
            clr_cyc = cyc;
        end
        for (int b = 0; b < NB; b++) begin
            if (cnt[b] > 0) begin
                cnt[b]--;
                if (cnt[b] == 0) begin
                    bus.band_avl[b]          = 1'b1;
                    bus.band_out[b*DW +: DW] = val[b];
                end
            end
            if (bus.band_en[b]) begin
                bus.band_avl[b] = 1'b0;
                cnt[b]          = never[b] ? 0 : lat[b];
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  64'(bus.busy),        64'd0);
        chk({tag, "_en"},    64'(bus.band_en),     64'd0);
        chk({tag, "_clr"},   64'(bus.band_clr),    64'd0);
        chk({tag, "_ov"},    64'(bus.out_valid),   64'd0);
        chk({tag, "_bands"}, 64'(bus.out_bands),   64'd0);
        chk({tag, "_bsmp"},  64'(bus.band_sample), 64'd0);
        chk({tag, "_drop"},  64'(bus.drop_cnt),    64'd0);
        chk({tag, "_tmo"},   64'(bus.timeout_err), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        check_zero({tag, "_imm"});
        @(posedge clk_fast);
        #1;
        cyc++;
        check_zero({tag, "_held"});
        for (int b = 0; b < NB; b++) begin
            cnt[b]   = 0;
            never[b] = 1'b0;
        end
        bus.band_avl = '0;
        bus.band_out = '0;
        exp_drop     = 0;
        exp_tmo      = 1'b0;
        rec          = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic clear_log();
        en_enc = '0; en_len = 0; ov_seen = 0; ov_cyc = -1;
        clr_seen = 0; clr_cyc = -1; busy_low = 0; bs_bad = 0;
    endtask

    // One sample through the scheduler. fixed_lat=0 -> random band latency;
    // never_b>=0 -> that band never raises avl; noise -> rejected samples and
    // a flush while busy, plus a sample in the first IDLE cycle afterwards.
    task automatic run_txn(input logic [NB-1:0] mask, input logic [DW-1:0] sample,
                           input int fixed_lat, input int never_b, input bit noise,
                           input string tag);
        int               t0, exp_done, x_len, k, rel;
        logic [31:0]      x_enc;
        logic [NB*DW-1:0] x_bands;
        bit               hang;
        for (int b = 0; b < NB; b++) begin
            lat[b]   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
            val[b]   = DW'($urandom);
            never[b] = (b == never_b);
        end
        // reference: bands in ascending order, each costs latency+1 cycles
        exp_done = cyc + 1;
        x_enc = '0; x_len = 0; x_bands = '0; hang = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (mask[b] && !hang) begin
                x_enc = (x_enc << 4) | 32'(b);
                x_len++;
                if (never[b]) begin
`ifdef FIR_BAND_SCHED_WDOG_EN
                    exp_done += WDOG + 1;
                    x_bands[b*DW +: DW] = '1;
                    exp_tmo = 1'b1;
`else
                    hang = 1'b1;
`endif
                end else begin
                    exp_done += lat[b] + 1;
                    x_bands[b*DW +: DW] = val[b];
                end
            end
        end
        clear_log();
        exp_sample       = sample;
        t0               = cyc;
        bus.sample_in    = sample;
        bus.band_mask    = mask;
        bus.sample_valid = 1'b1;
        rec              = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        bus.sample_in    = DW'($urandom);
        bus.band_mask    = NB'($urandom);
        k = 0;
        while (ov_seen == 0 && k < (hang ? 300 : 1500)) begin
            rel = cyc - t0;
            bus.sample_valid = noise && (rel == 2 || rel == 4 || rel == 6);
            bus.flush        = noise && (rel == 3);
            if (bus.sample_valid) exp_drop++;
            tick();
            k++;
        end
        bus.sample_valid = 1'b0;
        bus.flush        = 1'b0;
        chk({tag, "_en_order"}, 64'(en_enc),       64'(x_enc));
        chk({tag, "_en_count"}, 64'(en_len),       64'(x_len));
        chk({tag, "_bsmp_hold"}, 64'(bs_bad),      64'd0);
        chk({tag, "_tmo"},      64'(bus.timeout_err), 64'(exp_tmo));
        if (hang) begin
            chk({tag, "_no_ov"},     64'(ov_seen),  64'd0);
            chk({tag, "_busy_held"}, 64'(busy_low), 64'd0);
            chk({tag, "_busy_now"},  64'(bus.busy), 64'd1);
        end else begin
            chk({tag, "_ov_cycle"}, 64'(ov_cyc - t0), 64'(exp_done - t0));
            chk({tag, "_bands"},    64'(ov_bands),    64'(x_bands));
            chk({tag, "_busy"},     64'(busy_low),    64'd0);
            if (noise) begin
                tick();
                bus.sample_valid = 1'b1;
                bus.band_mask    = NB'($urandom);
                exp_drop++;
                tick();
                bus.sample_valid = 1'b0;
                chk({tag, "_pend_reject"}, 64'(bus.busy), 64'd0);
                tick();
                tick();
                chk({tag, "_clr_count"}, 64'(clr_seen),         64'd1);
                chk({tag, "_clr_cycle"}, 64'(clr_cyc - ov_cyc), 64'd2);
            end else begin
                tick(); tick(); tick();
                chk({tag, "_no_clr"},  64'(clr_seen),      64'd0);
                chk({tag, "_idle"},    64'(bus.busy),      64'd0);
                chk({tag, "_stable"},  64'(bus.out_bands), 64'(x_bands));
            end
            chk({tag, "_ov_once"}, 64'(ov_seen), 64'd1);
        end
        chk({tag, "_drop"}, 64'(bus.drop_cnt), 64'((exp_drop > 255) ? 255 : exp_drop));
        $display("txn %s mask=%b sample=%h en=%h ov_cyc=%0d bands=%h drop=%0d",
                 tag, mask, sample, en_enc, ov_cyc - t0, ov_bands, bus.drop_cnt);
    endtask

    initial begin
        bus.sample_in = '0; bus.sample_valid = 1'b0; bus.flush = 1'b0;
        bus.band_mask = '0; bus.band_out = '0; bus.band_avl = '0;
        for (int b = 0; b < NB; b++) begin cnt[b] = 0; never[b] = 1'b0; end
        clear_log();
        #3;
        do_reset("reset");

        run_txn(4'b1111, 10'h155, 5, -1, 1'b0, "all_bands");
        run_txn(4'b0101, DW'($urandom), 0, -1, 1'b0, "mask_0101");
        run_txn(4'b0000, DW'($urandom), 0, -1, 1'b0, "mask_none");
        for (int i = 0; i < 8; i++)
            run_txn(NB'($urandom), DW'($urandom), 0, -1, 1'b0, $sformatf("rand%0d", i));

        run_txn(4'b1111, DW'($urandom), 5, -1, 1'b1, "busy_noise");

        // flush and sample together in IDLE: clear pulse, sample dropped
        clear_log();
        bus.flush = 1'b1; bus.sample_valid = 1'b1; exp_drop++;
        tick();
        bus.flush = 1'b0; bus.sample_valid = 1'b0;
        chk("idle_flush_clr",  64'(bus.band_clr), 64'd1);
        chk("idle_flush_busy", 64'(bus.busy),     64'd0);
        tick();
        chk("idle_flush_clr_end", 64'(bus.band_clr), 64'd0);
        chk("idle_flush_drop", 64'(bus.drop_cnt), 64'(exp_drop));
        $display("txn idle_flush clr_seen=%0d drop=%0d", clr_seen, bus.drop_cnt);

        // reset while waiting on band 1
        clear_log();
        for (int b = 0; b < NB; b++) begin lat[b] = 5; never[b] = 1'b0; end
        bus.sample_in = DW'($urandom); bus.band_mask = 4'b1111; bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        repeat (8) tick();
        chk("midrst_issued", 64'(en_enc), 64'h01);
        chk("midrst_busy",   64'(bus.busy), 64'd1);
        do_reset("midrst");
        run_txn(4'b1111, DW'($urandom), 0, -1, 1'b0, "after_rst");
        chk("after_rst_single_ov", 64'(ov_seen), 64'd1);

        // band 2 never answers
        run_txn(4'b1111, DW'($urandom), 3, 2, 1'b0, "stuck_band2");
        do_reset("post_stuck");

        // drop counter saturation
        bus.flush = 1'b1; bus.sample_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin exp_drop++; tick(); end
        bus.flush = 1'b0; bus.sample_valid = 1'b0;
        tick();
        chk("drop_saturate", 64'(bus.drop_cnt), 64'((exp_drop > 255) ? 255 : exp_drop));
        chk("drop_sat_idle", 64'(bus.busy), 64'd0);
        $display("txn saturate rejected=%0d drop=%0d", exp_drop, bus.drop_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
